// File: rtl/gcd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gcd_sequencer
// Description : Feeds operand pairs to the GCD core over its shared data bus
//               (A with a start pulse, then B), waits for completion with a
//               cycle timeout, and returns the result over valid/ready.
//               Zero operands bypass the core entirely.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  // operand pair intake
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  // core interface
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  // result delivery
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             bypass,
  output logic             timeout
);

  // Timer spans 0..TIMEOUT-1 exactly; TIMEOUT >= 2 keeps the width >= 1.
  localparam int             TW           = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  c_timer_last = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_WAIT   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t            r_state,     w_state_next;
  logic [WIDTH-1:0]  r_b,         w_b_next;
  logic [TW-1:0]     r_timer,     w_timer_next;
  logic              r_in_ready,  w_in_ready_next;
  logic              r_start,     w_start_next;
  logic [WIDTH-1:0]  r_data,      w_data_next;
  logic              r_out_valid, w_out_valid_next;
  logic [WIDTH-1:0]  r_result,    w_result_next;
  logic              r_bypass,    w_bypass_next;
  logic              r_timeout,   w_timeout_next;

  // Every output is a flop; the next-state logic below computes the value
  // each output must carry in the cycle after the coming edge.
  assign in_ready  = r_in_ready;
  assign gcd_start = r_start;
  assign gcd_data  = r_data;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign bypass    = r_bypass;
  assign timeout   = r_timeout;

  // State and output registers; reset aborts any in-flight pair at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_b         <= '0;
      r_timer     <= '0;
      r_in_ready  <= 1'b1;
      r_start     <= 1'b0;
      r_data      <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_bypass    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_b         <= w_b_next;
      r_timer     <= w_timer_next;
      r_in_ready  <= w_in_ready_next;
      r_start     <= w_start_next;
      r_data      <= w_data_next;
      r_out_valid <= w_out_valid_next;
      r_result    <= w_result_next;
      r_bypass    <= w_bypass_next;
      r_timeout   <= w_timeout_next;
    end
  end

  // Next-state and next-output decode for the sequencing FSM.
  always_comb begin
    w_state_next     = r_state;
    w_b_next         = r_b;
    w_timer_next     = r_timer;
    w_in_ready_next  = r_in_ready;
    w_start_next     = 1'b0;
    w_data_next      = r_data;
    w_out_valid_next = r_out_valid;
    w_result_next    = r_result;
    w_bypass_next    = r_bypass;
    w_timeout_next   = r_timeout;

    case (r_state)
      S_IDLE: begin
        w_in_ready_next = 1'b1;
        if (in_valid && r_in_ready) begin
          w_b_next        = b_in;
          w_in_ready_next = 1'b0;
          if ((a_in == '0) || (b_in == '0)) begin
            // gcd(0,x)=x and gcd(0,0)=0; the core would never finish.
            w_result_next    = a_in | b_in;
            w_bypass_next    = 1'b1;
            w_timeout_next   = 1'b0;
            w_out_valid_next = 1'b1;
            w_data_next      = '0;
            w_state_next     = S_HOLD;
          end else begin
            // A goes on the bus together with the start pulse.
            w_start_next = 1'b1;
            w_data_next  = a_in;
            w_state_next = S_LOAD_A;
          end
        end
      end

      S_LOAD_A: begin
        // Core takes A on this edge; B follows on the bus next cycle.
        w_data_next  = r_b;
        w_state_next = S_LOAD_B;
      end

      S_LOAD_B: begin
        // Core takes B on this edge; WAIT starts with a fresh timer.
        w_timer_next = '0;
        w_state_next = S_WAIT;
      end

      S_WAIT: begin
        if (r_timer != c_timer_last) begin
          w_timer_next = r_timer + TW'(1);
        end
        // A completion on the boundary cycle takes priority over the abort.
        if (gcd_done) begin
          w_result_next    = gcd_result;
          w_out_valid_next = 1'b1;
          w_data_next      = '0;
          w_state_next     = S_HOLD;
        end else if (r_timer == c_timer_last) begin
          w_result_next    = '0;
          w_timeout_next   = 1'b1;
          w_out_valid_next = 1'b1;
          w_data_next      = '0;
          w_state_next     = S_HOLD;
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          w_out_valid_next = 1'b0;
          w_bypass_next    = 1'b0;
          w_timeout_next   = 1'b0;
          w_in_ready_next  = 1'b1;
          w_state_next     = S_IDLE;
        end
      end

      default: begin
        w_in_ready_next  = 1'b1;
        w_data_next      = '0;
        w_out_valid_next = 1'b0;
        w_state_next     = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
